// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter with return-address stack.
// Pure declarations: no logic, no latency, no flow control.
// Build option PC_RELBRANCH_EN adds the relative-branch op to the top level.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_t;

    localparam int PC_RESET_ADDR = 0;

    // The pointer must count 0..depth inclusive so that "full" is representable.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Decoder-to-PC bundle: control strobes and target in, registered address and stack status out.
// No handshake; the PC accepts one op per cycle. BRANCH exists only with PC_RELBRANCH_EN.
// Backpressure: none, strobes are sampled every rising edge.
interface pc_stack_unit_if #(parameter int WIDTH = 8);

    logic             PCEN;
    logic             LOAD;
    logic             CALL;
    logic             RET;
    logic [WIDTH-1:0] IN;
    logic [WIDTH-1:0] A;
    logic             STACK_EMPTY;
    logic             STACK_FULL;
    logic             OVF;
    logic             UNF;
`ifdef PC_RELBRANCH_EN
    logic             BRANCH;
`endif

    modport master (
`ifdef PC_RELBRANCH_EN
        output BRANCH,
`endif
        output PCEN, LOAD, CALL, RET, IN,
        input  A, STACK_EMPTY, STACK_FULL, OVF, UNF
    );

    modport slave (
`ifdef PC_RELBRANCH_EN
        input  BRANCH,
`endif
        input  PCEN, LOAD, CALL, RET, IN,
        output A, STACK_EMPTY, STACK_FULL, OVF, UNF
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push writes at sp, pop exposes entry sp-1 combinationally from registers.
// Latency: push/pop take effect on the next rising edge; empty/full decode the registered pointer.
// Backpressure: none; caller must not push when full or pop when empty (ignored if it does).
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int SPW  = sp_width(DEPTH);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0]   sp_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDXW-1:0]  wr_idx;
    logic [IDXW-1:0]  rd_idx;

    assign empty  = (sp_q == '0);
    assign full   = (sp_q == SPW'(DEPTH));
    assign wr_idx = IDXW'(sp_q);
    assign rd_idx = IDXW'(sp_q - SPW'(1));
    // Gate the read so a non-power-of-two depth never indexes past the array when empty.
    assign dout   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// WIDTH-bit program counter with increment, load, call/return stack and sticky OVF/UNF (PC_RELBRANCH_EN adds BRANCH).
// Latency: every op lands on A one rising edge after the strobe; A is purely registered.
// Backpressure: none; one op per cycle, priority RET > CALL > BRANCH > LOAD > PCEN.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic           Clock,
    input  logic           RESET,
    pc_stack_unit_if.slave bus
);

    op_t              op;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] a_inc;
    logic [WIDTH-1:0] ret_addr;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             ovf_q;
    logic             unf_q;

    assign a_inc = a_q + WIDTH'(1);

    always_comb begin
        op = OP_HOLD;
        if (bus.RET) begin
            op = OP_RET;
        end else if (bus.CALL) begin
            op = OP_CALL;
`ifdef PC_RELBRANCH_EN
        end else if (bus.BRANCH) begin
            op = OP_BRANCH;
`endif
        end else if (bus.LOAD) begin
            op = OP_LOAD;
        end else if (bus.PCEN) begin
            op = OP_INC;
        end
    end

    assign push = (op == OP_CALL) && !full;
    assign pop  = (op == OP_RET) && !empty;

    always_comb begin
        a_nxt = a_q;
        case (op)
            OP_INC:    a_nxt = a_inc;
            OP_LOAD:   a_nxt = bus.IN;
            // Same-width modular add is exactly A + sign-extended offset.
            OP_BRANCH: a_nxt = a_q + bus.IN;
            OP_CALL:   if (!full)  a_nxt = bus.IN;
            OP_RET:    if (!empty) a_nxt = ret_addr;
            default:   a_nxt = a_q;
        endcase
    end

    always_ff @(posedge Clock or negedge RESET) begin
        if (!RESET) begin
            a_q   <= WIDTH'(PC_RESET_ADDR);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            a_q <= a_nxt;
            if (op == OP_CALL && full) begin
                ovf_q <= 1'b1;
            end
            if (op == OP_RET && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    // The pushed return address is the pre-call A+1, so a self-call returns past itself.
    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (Clock),
        .rst_n (RESET),
        .push  (push),
        .pop   (pop),
        .din   (a_inc),
        .dout  (ret_addr),
        .empty (empty),
        .full  (full)
    );

    assign bus.A           = a_q;
    assign bus.STACK_EMPTY = empty;
    assign bus.STACK_FULL  = full;
    assign bus.OVF         = ovf_q;
    assign bus.UNF         = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboarded bench for pc_stack_unit (WIDTH=8, STACK_DEPTH=4); BRANCH cases under PC_RELBRANCH_EN.
module tb_pc_stack_unit;

    typedef struct packed {
        logic       pcen;
        logic       load;
        logic       call;
        logic       ret;
        logic       branch;
        logic [7:0] in;
        logic [7:0] expa;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_a;

    always #5 clk = ~clk;

    pc_stack_unit_if #(.WIDTH(8)) bus ();

    pc_stack_unit #(
        .WIDTH       (8),
        .STACK_DEPTH (4)
    ) dut (
        .Clock (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    function automatic stim_t mk(input logic pcen, input logic load, input logic call,
                                 input logic ret, input logic branch,
                                 input logic [7:0] in, input logic [7:0] expa);
        stim_t s;
        s.pcen = pcen; s.load = load; s.call = call; s.ret = ret;
        s.branch = branch; s.in = in; s.expa = expa;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        bus.PCEN = s.pcen;
        bus.LOAD = s.load;
        bus.CALL = s.call;
        bus.RET  = s.ret;
        bus.IN   = s.in;
`ifdef PC_RELBRANCH_EN
        bus.BRANCH = s.branch;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus.A !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", bus.A); end
        checks++; if (bus.STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.STACK_EMPTY); end
        checks++; if (bus.STACK_FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.STACK_FULL); end
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.OVF); end
        checks++; if (bus.UNF !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b want 0", bus.UNF); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_inc_wrap();
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(8'((i + 1) % 256));
            drive(mk(1, 0, 0, 0, 0, 8'h00, 8'h00));
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL inc[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
        checks++; if (bus.A !== 8'd44) begin errors++; $display("FAIL inc_final: got %h want 2c", bus.A); end
        checks++; if ({bus.OVF, bus.UNF} !== 2'b00) begin errors++; $display("FAIL inc_flags: got %b want 00", {bus.OVF, bus.UNF}); end
    endtask

    task automatic test_load();
        stim_t v [$];
        v.push_back(mk(0, 1, 0, 0, 0, 8'h3C, 8'h3C));
        v.push_back(mk(1, 0, 0, 0, 0, 8'hAA, 8'h3D));
        v.push_back(mk(0, 0, 0, 0, 0, 8'h77, 8'h3D));
        foreach (v[i]) begin
            exp_q.push_back(v[i].expa);
            drive(v[i]);
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL load[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
    endtask

    task automatic test_call_ret();
        stim_t v [$];
        v.push_back(mk(0, 1, 0, 0, 0, 8'h10, 8'h10));
        v.push_back(mk(0, 0, 1, 0, 0, 8'h80, 8'h80));
        v.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h81));
        v.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h82));
        v.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h11));
        foreach (v[i]) begin
            exp_q.push_back(v[i].expa);
            drive(v[i]);
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL call_ret[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
        checks++; if (bus.STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL call_ret_empty: got %b want 1", bus.STACK_EMPTY); end
    endtask

    task automatic test_nested();
        stim_t calls [$];
        stim_t rets [$];
        // Starting at A=0x11: return addresses 0x12, 0x41, 0x51, 0x61.
        calls.push_back(mk(0, 0, 1, 0, 0, 8'h40, 8'h40));
        calls.push_back(mk(0, 0, 1, 0, 0, 8'h50, 8'h50));
        calls.push_back(mk(0, 0, 1, 0, 0, 8'h60, 8'h60));
        calls.push_back(mk(0, 0, 1, 0, 0, 8'h70, 8'h70));
        foreach (calls[i]) begin
            exp_q.push_back(calls[i].expa);
            drive(calls[i]);
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL nest_call[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
        checks++; if (bus.STACK_FULL !== 1'b1) begin errors++; $display("FAIL nest_full: got %b want 1", bus.STACK_FULL); end
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL nest_ovf_pre: got %b want 0", bus.OVF); end
        drive(mk(0, 0, 1, 0, 0, 8'h99, 8'h70));
        checks++; if (bus.A !== 8'h70) begin errors++; $display("FAIL nest_ovf_a: got %h want 70", bus.A); end
        checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL nest_ovf: got %b want 1", bus.OVF); end
        rets.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h61));
        rets.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h51));
        rets.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h41));
        rets.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h12));
        foreach (rets[i]) begin
            exp_q.push_back(rets[i].expa);
            drive(rets[i]);
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL nest_ret[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
        checks++; if (bus.STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL nest_empty: got %b want 1", bus.STACK_EMPTY); end
        checks++; if (bus.UNF !== 1'b0) begin errors++; $display("FAIL nest_unf_pre: got %b want 0", bus.UNF); end
        drive(mk(0, 0, 0, 1, 0, 8'h00, 8'h12));
        checks++; if (bus.A !== 8'h12) begin errors++; $display("FAIL nest_unf_a: got %h want 12", bus.A); end
        checks++; if (bus.UNF !== 1'b1) begin errors++; $display("FAIL nest_unf: got %b want 1", bus.UNF); end
        checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL nest_ovf_sticky: got %b want 1", bus.OVF); end
    endtask

    task automatic test_priority();
        stim_t v [$];
        v.push_back(mk(0, 1, 0, 0, 0, 8'h20, 8'h20));
        v.push_back(mk(1, 1, 1, 0, 0, 8'h40, 8'h40));
        v.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'h21));
        v.push_back(mk(1, 1, 0, 0, 0, 8'h33, 8'h33));
        // Recursive self-call: IN equals current A, return lands one past it.
        v.push_back(mk(0, 0, 1, 0, 0, 8'h33, 8'h33));
        v.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h34));
        foreach (v[i]) begin
            exp_q.push_back(v[i].expa);
            drive(v[i]);
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL prio[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
        checks++; if (bus.STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL prio_empty: got %b want 1", bus.STACK_EMPTY); end
    endtask

    task automatic test_async_reset();
        drive(mk(0, 0, 1, 0, 0, 8'h30, 8'h30));
        drive(mk(0, 0, 1, 0, 0, 8'h31, 8'h31));
        checks++; if (bus.A !== 8'h31) begin errors++; $display("FAIL ares_pre_a: got %h want 31", bus.A); end
        drive(mk(0, 0, 0, 0, 0, 8'h00, 8'h31));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.A !== 8'h00) begin errors++; $display("FAIL ares_a: got %h want 00", bus.A); end
        checks++; if (bus.STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL ares_empty: got %b want 1", bus.STACK_EMPTY); end
        checks++; if ({bus.OVF, bus.UNF} !== 2'b00) begin errors++; $display("FAIL ares_flags: got %b want 00", {bus.OVF, bus.UNF}); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 8'h00, 8'h01));
        checks++; if (bus.A !== 8'h01) begin errors++; $display("FAIL ares_inc: got %h want 01", bus.A); end
        drive(mk(0, 0, 0, 1, 0, 8'h00, 8'h01));
        checks++; if (bus.A !== 8'h01) begin errors++; $display("FAIL ares_ret_a: got %h want 01", bus.A); end
        checks++; if (bus.UNF !== 1'b1) begin errors++; $display("FAIL ares_unf: got %b want 1", bus.UNF); end
    endtask

`ifdef PC_RELBRANCH_EN
    task automatic test_branch();
        stim_t v [$];
        v.push_back(mk(0, 1, 0, 0, 0, 8'h05, 8'h05));
        v.push_back(mk(0, 0, 0, 0, 1, 8'hFE, 8'h03));
        v.push_back(mk(1, 1, 0, 0, 1, 8'h10, 8'h13));
        v.push_back(mk(0, 0, 1, 0, 1, 8'h50, 8'h50));
        v.push_back(mk(0, 0, 0, 1, 1, 8'h02, 8'h14));
        foreach (v[i]) begin
            exp_q.push_back(v[i].expa);
            drive(v[i]);
            exp_a = exp_q.pop_front();
            checks++;
            if (bus.A !== exp_a) begin errors++; $display("FAIL branch[%0d]: got %h want %h", i, bus.A, exp_a); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        bus.PCEN = 1'b0;
        bus.LOAD = 1'b0;
        bus.CALL = 1'b0;
        bus.RET  = 1'b0;
        bus.IN   = 8'h00;
`ifdef PC_RELBRANCH_EN
        bus.BRANCH = 1'b0;
`endif
        #2;
        test_reset();
        test_inc_wrap();
        test_load();
        test_call_ret();
        test_nested();
        test_priority();
        test_async_reset();
`ifdef PC_RELBRANCH_EN
        test_branch();
`endif
        drive(mk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program counter for the next-generation core sequencer. It generalises the 4-bit incrementing PC to WIDTH bits and adds absolute load, subroutine call/return through an internal LIFO return-address stack, and sticky stack-error flags. The block sits between the instruction decoder, which supplies the control strobes and target address, and instruction memory, which is addressed by A.

Parameters:
WIDTH, 8, PC / address width in bits (minimum 2)
STACK_DEPTH, 4, return-address stack entries (minimum 1)

Ports:
Clock  input  1  system clock; all state updates on the rising edge
RESET  input  1  asynchronous, active-low reset
PCEN  input  1  increment enable; PC <= PC+1
LOAD  input  1  absolute jump; PC <= IN
CALL  input  1  subroutine call; push PC+1, then PC <= IN
RET  input  1  subroutine return; PC <= popped address
IN  input  WIDTH  jump/call target (relative offset when BRANCH is used)
A  output  WIDTH  current PC, registered
STACK_EMPTY  output  1  stack pointer == 0
STACK_FULL  output  1  stack pointer == STACK_DEPTH
OVF  output  1  sticky: CALL was attempted while the stack was full
UNF  output  1  sticky: RET was attempted while the stack was empty
BRANCH  input  1  relative branch; port present only with PC_RELBRANCH_EN

Behaviour:
- Reset (RESET low, asynchronous): A=0, SP=0, STACK_EMPTY=1, STACK_FULL=0, OVF=0, UNF=0. Stack contents are don't-care. Reset applied mid-operation aborts any pending op; the first edge after release behaves normally.
- One operation per cycle. Priority when strobes are simultaneous: RET > CALL > (BRANCH) > LOAD > PCEN. None asserted: PC holds.
- PCEN: A <= A+1 modulo 2^WIDTH. All-ones wraps to 0 with no flag.
- LOAD: A <= IN.
- CALL, not full: stack[SP] <= (A+1) mod 2^WIDTH, SP <= SP+1, A <= IN. All of these take effect on the same edge.
- CALL, full: no push, A holds, OVF <= 1.
- RET, not empty: A <= stack[SP-1], SP <= SP-1.
- RET, empty: A holds, UNF <= 1.
- Latency: every op is visible on A one edge after the strobe is sampled. There is no combinational path from inputs to A.
- SP width is clog2(STACK_DEPTH+1). Flags are decoded from the registered SP.
- OVF and UNF are sticky until RESET.
- CALL with IN equal to the current A is legal; this is a recursive self-call.

Optional Feature:
Macro PC_RELBRANCH_EN.
- Defined: BRANCH port exists. BRANCH applies A <= A + sign-extended IN (two's complement, modulo 2^WIDTH). It has priority below CALL and above LOAD, and does not touch the stack.
- Undefined: BRANCH port is absent. Behaviour is exactly as above.

Decomposition:
- Package pc_pkg: the op-select enum (OP_HOLD, OP_INC, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET), a function computing the SP width from STACK_DEPTH, and the reset-address constant PC_RESET_ADDR = 0.
- Sub-module pc_ret_stack: a LIFO with push/pop, data in/out, empty/full, and its own async active-low reset.
- The top level holds the priority decode, the A register, the adder and the sticky flags.

Test Plan:
- Reset then 300 PCEN cycles with WIDTH=8 -> A goes 0..255, wraps to 0, then continues to 44. No flags set.
- LOAD with IN=0x3C, next cycle PCEN -> A=0x3C, then 0x3D.
- At A=0x10: CALL IN=0x80, two PCEN cycles, then RET -> A sequence 0x80, 0x81, 0x82, 0x11. STACK_EMPTY=1 at the end.
- STACK_DEPTH=4: five nested CALLs -> STACK_FULL after the 4th call. The 5th call leaves A unchanged and sets OVF=1. Four RETs then unwind correctly, and a 5th RET sets UNF=1 with A held.
- CALL, LOAD and PCEN asserted together at A=0x20 with IN=0x40 -> A=0x40 and the stack top is 0x21. Then RET and PCEN together -> A=0x21.
- Assert RESET asynchronously mid-cycle after two CALLs -> A=0, SP=0 and flags are cleared immediately, before the next clock edge. With PC_RELBRANCH_EN defined: at A=0x05, BRANCH with IN=0xFE -> A=0x03.
